seq_detect_param: RTL
=====================

Name: seq_detect_param

Overview:
Parametrised serial bit-pattern detector. It is the generalised successor to the fixed-pattern FSM detectors. It accepts one serial bit per enabled clock and compares a sliding window of the last PAT_LEN bits against a configurable pattern. It raises a registered one-cycle Mealy-style match pulse, supports overlapping and non-overlapping detection selectable at run time, and keeps a saturating match counter for status.

Parameters:
PAT_LEN, 5, pattern length in bits; legal range 2..32
PATTERN, 5'b11011, pattern to detect; MSB is the first bit received
CNT_W, 8, width of the match counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  bit-valid qualifier; signal is sampled only when en=1
signal  input  1  serial data bit
overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled with each bit
clr  input  1  synchronous clear of history, fill and counter
out  output  1  registered match pulse
match_cnt  output  CNT_W  saturating count of matches since reset or clr

Behaviour:
- Reset values (rst=1, asynchronous): out=0, match_cnt=0, fill=0, history=0.
- Internal state:
  - hist: PAT_LEN-1 bits. The most recently sampled bit is the LSB.
  - fill: counts valid history bits, range 0..PAT_LEN-1, saturating at PAT_LEN-1.
- On each rising edge with rst=0, these rules apply in priority order:
  - clr=1: fill<=0, hist<=0, match_cnt<=0, out<=0. Any bit presented in the same cycle is discarded.
  - en=0: out<=0. hist, fill and match_cnt hold. Idle cycles are transparent, so a pattern may span en gaps.
  - en=1:
    - window = {hist, signal}.
    - match = (fill == PAT_LEN-1) && (window == PATTERN).
    - out <= match.
    - hist <= {hist[PAT_LEN-3:0], signal}.
    - If match=1 and overlap=0: fill<=0, so no bit of the matched pattern can contribute to a later match.
    - Otherwise: fill <= min(fill+1, PAT_LEN-1).
    - If match=1: match_cnt <= match_cnt+1, saturating at 2^CNT_W-1 with no wrap.
- Latency: out is high for exactly the one cycle following the edge that sampled the final pattern bit. There is no combinational path from inputs to out.
- Back-to-back matches:
  - With overlap=1, out may be high on consecutive cycles (e.g. PATTERN=all ones).
  - With overlap=0, successive pulses are at least PAT_LEN enabled samples apart.
- Changing overlap takes effect on the bit sampled in the same cycle. No flush is required.
- Reset asserted mid-pattern discards all partial progress. The first match after reset needs PAT_LEN fresh enabled bits.
- The detector has no internal FSM encoding. Correctness follows from the window compare, so every pattern (including self-overlapping ones) is detected exactly.

Test Plan:
- Overlap mode, defaults. Stream 1,1,0,1,1,0,1,1 with en=1 and overlap=1 -> out pulses in the cycle after bit 5 and after bit 8; match_cnt=2.
- Non-overlap mode. Same stream with overlap=0 -> out pulses only after bit 5; match_cnt=1.
- Reset mid-pattern. Feed 1,1,0,1, pulse rst for 1 cycle, then feed 1 -> out stays 0, match_cnt=0. Then feed 1,1,0,1,1 -> one pulse.
- en gaps. Feed 1,1, then 3 cycles with en=0 and signal=0, then 0,1,1 -> single match pulse after the final 1. out=0 during the gap.
- PATTERN=3'b111, PAT_LEN=3, CNT_W=2. Ten consecutive 1s:
  - overlap=1 -> out high for 8 consecutive cycles starting after bit 3; match_cnt saturates at 3.
  - overlap=0 -> pulses after bits 3, 6 and 9.
- clr priority. Assert clr in the same cycle as the final 1 of 1,1,0,1,1 -> out=0 and match_cnt=0. The next 4 bits 1,0,1,1 produce no match.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial bit-pattern detector with a sliding-window compare.
// The detector keeps the last PAT_LEN-1 sampled bits and compares them, with
// the bit being sampled now, against PATTERN. A fill counter makes sure that
// only bits received since reset, clr or a non-overlapping match can
// contribute to a match. It reports a registered one-cycle match pulse and a
// saturating match count.
module seq_detect_param #(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b11011,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             signal,
  input  logic             overlap,
  input  logic             clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  // fill only needs to reach PAT_LEN-1. PAT_LEN >= 2 keeps this width at 1 or more.
  localparam int                FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] hist;
  logic [FILL_W-1:0]  fill;
  logic [PAT_LEN-1:0] window;
  logic               match;
  logic [FILL_W-1:0]  fill_next;
  logic               cnt_sat;

  // Window compare and next fill. The newest history bit is the LSB, so the
  // window lines up with PATTERN, whose MSB is the oldest bit.
  always_comb begin
    window    = {hist, signal};
    match     = (fill == FILL_MAX) && (window == PATTERN);
    cnt_sat   = &match_cnt;
    fill_next = fill;
    if (match && !overlap) begin
      // Non-overlapping mode: the matched bits may not be used again.
      fill_next = '0;
    end else if (fill != FILL_MAX) begin
      fill_next = fill + FILL_W'(1);
    end
  end

  // State update. clr has priority over en, and idle cycles hold all state so
  // that a pattern may span gaps in en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= 1'b0;
      match_cnt <= '0;
      fill      <= '0;
      hist      <= '0;
    end else if (clr) begin
      out       <= 1'b0;
      match_cnt <= '0;
      fill      <= '0;
      hist      <= '0;
    end else if (!en) begin
      out <= 1'b0;
    end else begin
      out  <= match;
      hist <= window[PAT_LEN-2:0];
      fill <= fill_next;
      if (match && !cnt_sat) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule
